// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / redirect / mult-div hazard controller for the 5-stage MIPS pipeline
//   in : clk, reset (sync, active-high), rsID/rtID/useRsID/useRtID (ID sources),
//        MemReadEX/rtEX/nopEX/BranchEX/zeroEX/JumpEX/multEX (ID/EX register outputs)
//   out: pc_en, pc_redirect, en_IFID, flush_IFID, en_IDEX, bubble_ID, bubble_EX, busy,
//        stall_cycles (saturating stall counter when HAZ_PERF_CNT_EN is defined, else 0)
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsID,
  input  logic [4:0]  rtID,
  input  logic        useRsID,
  input  logic        useRtID,
  input  logic        MemReadEX,
  input  logic [4:0]  rtEX,
  input  logic        nopEX,
  input  logic        BranchEX,
  input  logic        zeroEX,
  input  logic        JumpEX,
  input  logic        multEX,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        en_IFID,
  output logic        flush_IFID,
  output logic        en_IDEX,
  output logic        bubble_ID,
  output logic        bubble_EX,
  output logic        busy,
  output logic [31:0] stall_cycles
);
  typedef enum logic {RUN, MULT} state_t;
  localparam logic MULT_MULTI = (MULT_LAT > 1);
  localparam logic [3:0] CNT_START = 4'(MULT_LAT - 2);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic redirect, loaduse, mstart;
  always_comb begin
    redirect = ~nopEX & ((BranchEX & zeroEX) | JumpEX);
    loaduse = ~nopEX & MemReadEX & (rtEX != 5'd0) &
              ((useRsID & (rsID == rtEX)) | (useRtID & (rtID == rtEX)));
    mstart = ~nopEX & multEX & MULT_MULTI;
  end
  always_comb begin
    pc_en = 1'b1;
    en_IFID = 1'b1;
    en_IDEX = 1'b1;
    pc_redirect = 1'b0;
    flush_IFID = 1'b0;
    bubble_ID = 1'b0;
    bubble_EX = 1'b0;
    busy = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    if (reset) begin
      pc_en = 1'b0;
      en_IFID = 1'b0;
      en_IDEX = 1'b0;
      bubble_ID = 1'b1;
      bubble_EX = 1'b1;
      state_d = RUN;
      cnt_d = 4'd0;
    end else if (state_q == MULT) begin
      // The release cycle (cnt==0) lets the pipe advance and ignores all new hazards.
      busy = 1'b1;
      if (cnt_q != 4'd0) begin
        pc_en = 1'b0;
        en_IFID = 1'b0;
        en_IDEX = 1'b0;
        bubble_EX = 1'b1;
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = RUN;
      end
    end else if (redirect) begin
      pc_redirect = 1'b1;
      flush_IFID = 1'b1;
      bubble_ID = 1'b1;
    end else if (mstart) begin
      // This cycle is the first of MULT_LAT in EX; MULT covers the remaining MULT_LAT-1.
      pc_en = 1'b0;
      en_IFID = 1'b0;
      en_IDEX = 1'b0;
      bubble_EX = 1'b1;
      state_d = MULT;
      cnt_d = CNT_START;
    end else if (loaduse) begin
      pc_en = 1'b0;
      en_IFID = 1'b0;
      bubble_ID = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (~pc_en & ~&stall_q) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= 32'd0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + randomized check of pipe_hazard_ctrl against a cycle-level model
module tb_pipe_hazard_ctrl;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsID, rtID, rtEX;
  logic useRsID, useRtID, MemReadEX, nopEX, BranchEX, zeroEX, JumpEX, multEX;
  logic pc_en, pc_redirect, en_IFID, flush_IFID, en_IDEX, bubble_ID, bubble_EX, busy;
  logic [31:0] stall_cycles;
  int n_tests = 0;
  int n_fail = 0;
  int hold_left = 0;
  longint exp_stall = 0;
  logic e_pc, e_red, e_ifid, e_flush, e_idex, e_bid, e_bex, e_busy;
  pipe_hazard_ctrl #(.MULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .rsID(rsID), .rtID(rtID), .useRsID(useRsID), .useRtID(useRtID),
    .MemReadEX(MemReadEX), .rtEX(rtEX), .nopEX(nopEX), .BranchEX(BranchEX), .zeroEX(zeroEX),
    .JumpEX(JumpEX), .multEX(multEX), .pc_en(pc_en), .pc_redirect(pc_redirect),
    .en_IFID(en_IFID), .flush_IFID(flush_IFID), .en_IDEX(en_IDEX), .bubble_ID(bubble_ID),
    .bubble_EX(bubble_EX), .busy(busy), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle();
    reset = 0; rsID = 0; rtID = 0; rtEX = 0; useRsID = 0; useRtID = 0; MemReadEX = 0;
    nopEX = 0; BranchEX = 0; zeroEX = 0; JumpEX = 0; multEX = 0;
  endtask
  function automatic longint perf_exp();
`ifdef HAZ_PERF_CNT_EN
    return exp_stall;
`else
    return 0;
`endif
  endfunction
  task automatic model();
    bit red, ms, lu;
    red = !nopEX && ((BranchEX && zeroEX) || JumpEX);
    ms = !nopEX && multEX && LAT > 1;
    lu = !nopEX && MemReadEX && rtEX != 0 &&
         ((useRsID && rsID == rtEX) || (useRtID && rtID == rtEX));
    {e_pc, e_ifid, e_idex, e_red, e_flush, e_bid, e_bex, e_busy} = 8'b1110_0000;
    if (reset) {e_pc, e_ifid, e_idex, e_red, e_flush, e_bid, e_bex, e_busy} = 8'b0000_0110;
    else if (hold_left > 1) {e_pc, e_ifid, e_idex, e_bex, e_busy} = 5'b00011;
    else if (hold_left == 1) e_busy = 1;
    else if (red) {e_red, e_flush, e_bid} = 3'b111;
    else if (ms) {e_pc, e_ifid, e_idex, e_bex} = 4'b0001;
    else if (lu) {e_pc, e_ifid, e_bid} = 3'b001;
  endtask
  task automatic advance();
    bit red, ms;
    red = !nopEX && ((BranchEX && zeroEX) || JumpEX);
    ms = !nopEX && multEX && LAT > 1;
    if (reset) hold_left = 0;
    else if (hold_left > 0) hold_left--;
    else if (!red && ms) hold_left = LAT - 1;
    if (reset) exp_stall = 0;
    else if (!e_pc && exp_stall < 64'hFFFF_FFFF) exp_stall++;
  endtask
  task automatic cycle();
    #1;
    model();
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
    chk("en_IFID", 32'(en_IFID), 32'(e_ifid));
    chk("flush_IFID", 32'(flush_IFID), 32'(e_flush));
    chk("en_IDEX", 32'(en_IDEX), 32'(e_idex));
    chk("bubble_ID", 32'(bubble_ID), 32'(e_bid));
    chk("bubble_EX", 32'(bubble_EX), 32'(e_bex));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("stall_cycles", stall_cycles, 32'(perf_exp()));
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask
  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    cycle();
    cycle();
    idle();
    cycle();
    MemReadEX = 1; rtEX = 8; rsID = 8; useRsID = 1;
    cycle();
    idle();
    cycle();
    multEX = 1;
    repeat (4) cycle();
    idle();
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("perf_after_lu_mult", stall_cycles, 32'd4);
`else
    chk("perf_disabled", stall_cycles, 32'd0);
`endif
    cycle();
    MemReadEX = 1; rtEX = 0; rsID = 0; useRsID = 1;
    cycle();
    rtEX = 8; rsID = 8; nopEX = 1;
    cycle();
    idle(); MemReadEX = 1; rtEX = 9; rtID = 9; useRtID = 1;
    cycle();
    idle(); BranchEX = 1; zeroEX = 1;
    cycle();
    zeroEX = 0;
    cycle();
    idle(); JumpEX = 1; MemReadEX = 1; rtEX = 8; rsID = 8; useRsID = 1;
    cycle();
    idle(); multEX = 1;
    cycle();
    cycle();
    reset = 1;
    cycle();
    idle();
    cycle();
    cycle();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      rsID = 5'($urandom_range(0, 3));
      rtID = 5'($urandom_range(0, 3));
      rtEX = 5'($urandom_range(0, 3));
      useRsID = 1'($urandom_range(0, 1));
      useRtID = 1'($urandom_range(0, 1));
      MemReadEX = ($urandom_range(0, 99) < 40);
      nopEX = ($urandom_range(0, 99) < 20);
      BranchEX = ($urandom_range(0, 99) < 15);
      zeroEX = 1'($urandom_range(0, 1));
      JumpEX = ($urandom_range(0, 99) < 8);
      multEX = ($urandom_range(0, 99) < 10);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
